// File: rtl/hazard_scoreboard_pkg.sv
// Shared widths, instruction-class Tnew/Tuse encodings and index-width helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_scoreboard_pkg;

    localparam int AW_DEF = 5;
    localparam int DW_DEF = 32;
    localparam int TW_DEF = 2;

    // Cycles after entering E until the result sits in a stage register.
    localparam logic [TW_DEF-1:0] TNEW_ALU  = 2'd1;
    localparam logic [TW_DEF-1:0] TNEW_LOAD = 2'd2;
    localparam logic [TW_DEF-1:0] TNEW_MFHI = 2'd1;

    // Cycles from D until an operand is actually consumed.
    localparam logic [TW_DEF-1:0] TUSE_0 = 2'd0;
    localparam logic [TW_DEF-1:0] TUSE_1 = 2'd1;
    localparam logic [TW_DEF-1:0] TUSE_2 = 2'd2;

    typedef enum logic [1:0] {
        CLS_ALU  = 2'd0,
        CLS_LOAD = 2'd1,
        CLS_MFHI = 2'd2,
        CLS_NONE = 2'd3
    } instr_class_e;

    // Width of an index into n entries; never zero so single-entry configs still have a port.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [TW_DEF-1:0] tnew_of(input instr_class_e c);
        case (c)
            CLS_ALU:  return TNEW_ALU;
            CLS_LOAD: return TNEW_LOAD;
            CLS_MFHI: return TNEW_MFHI;
            default:  return '0;
        endcase
    endfunction

endpackage

// File: rtl/hazard_scoreboard_match.sv
// Youngest-match priority encoder: finds the lowest-index valid entry writing rs.
// Latency: combinational.
// Backpressure: none; pure lookup.
// Ports: rs (operand register), ent_v/ent_a3/ent_tnew (scoreboard), hit/k/tnew (result).
module sb_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int AW    = AW_DEF,
    parameter int TW    = TW_DEF,
    parameter int KW    = idx_w(DEPTH)
)(
    input  logic [AW-1:0]       rs,
    input  logic [DEPTH-1:0]    ent_v,
    input  logic [DEPTH*AW-1:0] ent_a3,
    input  logic [DEPTH*TW-1:0] ent_tnew,
    output logic                hit,
    output logic [KW-1:0]       k,
    output logic [TW-1:0]       tnew
);

    // Scan oldest to youngest so the youngest (lowest index) match is the last write.
    // $0 is hardwired, so it never matches even if an entry somehow carries it.
    always_comb begin
        hit  = 1'b0;
        k    = '0;
        tnew = '0;
        for (int j = DEPTH - 1; j >= 0; j--) begin
            if (ent_v[j] && (ent_a3[j*AW +: AW] == rs) && (rs != '0)) begin
                hit  = 1'b1;
                k    = KW'(j);
                tnew = ent_tnew[j*TW +: TW];
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// D-stage hazard/forwarding unit: scoreboard of in-flight writers plus mult/div busy counter.
// Latency: stall/fwd_data/fwd_pending/md_busy are combinational from inputs and registered state.
// Backpressure: stall freezes F/D and injects a bubble into E; scoreboard keeps shifting regardless.
// Ports: clk/reset; d_* describe the D instruction; stage_wd holds per-stage results;
//        outputs stall, fwd_data, fwd_pending, md_busy.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NSRC   = 2,
    parameter int DEPTH  = 3,
    parameter int DW     = DW_DEF,
    parameter int AW     = AW_DEF,
    parameter int TW     = TW_DEF,
    parameter int MD_LAT = 5
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 d_valid,
    input  logic [NSRC*AW-1:0]   d_rs,
    input  logic [NSRC*TW-1:0]   d_tuse,
    input  logic [NSRC*DW-1:0]   d_rdata,
    input  logic                 d_regwrite,
    input  logic [AW-1:0]        d_a3,
    input  logic [TW-1:0]        d_tnew,
    input  logic                 d_md_start,
    input  logic                 d_md_use,
    input  logic [DEPTH*DW-1:0]  stage_wd,
    output logic                 stall,
    output logic [NSRC*DW-1:0]   fwd_data,
    output logic [NSRC-1:0]      fwd_pending,
    output logic                 md_busy
);

    localparam int KW = idx_w(DEPTH);
    localparam int CW = $clog2(MD_LAT + 1);

    // Scoreboard: index 0 = E, DEPTH-1 = oldest tracked stage.
    logic [DEPTH-1:0]    sb_v;
    logic [DEPTH*AW-1:0] sb_a3;
    logic [DEPTH*TW-1:0] sb_tnew;
    logic [CW-1:0]       md_cnt;

    logic [NSRC-1:0]     hit;
    logic [NSRC*KW-1:0]  hit_k;
    logic [NSRC*TW-1:0]  hit_tnew;
    logic                hazard;

    function automatic logic [TW-1:0] tdec(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - TW'(1);
    endfunction

    generate
        for (genvar i = 0; i < NSRC; i++) begin : g_match
            sb_match #(
                .DEPTH (DEPTH),
                .AW    (AW),
                .TW    (TW),
                .KW    (KW)
            ) u_match (
                .rs       (d_rs[i*AW +: AW]),
                .ent_v    (sb_v),
                .ent_a3   (sb_a3),
                .ent_tnew (sb_tnew),
                .hit      (hit[i]),
                .k        (hit_k[i*KW +: KW]),
                .tnew     (hit_tnew[i*TW +: TW])
            );
        end
    endgenerate

    // A ready producer (tnew 0) is forwarded from its stage; one that will be ready
    // before the operand is consumed is flagged pending for later forwarding;
    // anything later than that is a hazard.
    always_comb begin
        hazard      = 1'b0;
        fwd_data    = d_rdata;
        fwd_pending = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (d_valid && hit[i]) begin
                if (hit_tnew[i*TW +: TW] == '0)
                    fwd_data[i*DW +: DW] = stage_wd[int'(hit_k[i*KW +: KW])*DW +: DW];
                else if (hit_tnew[i*TW +: TW] <= d_tuse[i*TW +: TW])
                    fwd_pending[i] = 1'b1;
                else
                    hazard = 1'b1;
            end
        end
    end

    assign md_busy = (md_cnt != '0);
    // d_md_use covers mult/div starts too, so a start while busy stalls and never reloads.
    assign stall   = d_valid & (hazard | (d_md_use & md_busy));

    always_ff @(posedge clk) begin
        if (reset) begin
            sb_v    <= '0;
            sb_a3   <= '0;
            sb_tnew <= '0;
            md_cnt  <= '0;
        end else begin
            for (int k = 1; k < DEPTH; k++) begin
                sb_v[k]            <= sb_v[k-1];
                sb_a3[k*AW +: AW]  <= sb_a3[(k-1)*AW +: AW];
                sb_tnew[k*TW +: TW] <= tdec(sb_tnew[(k-1)*TW +: TW]);
            end
            // A stalled D instruction becomes a bubble in E.
            sb_v[0]        <= ~stall & d_valid & d_regwrite & (d_a3 != '0);
            sb_a3[0 +: AW] <= d_a3;
            sb_tnew[0 +: TW] <= d_tnew;

            if (d_valid && d_md_start && !stall)
                md_cnt <= CW'(MD_LAT);
            else if (md_cnt != '0)
                md_cnt <= md_cnt - CW'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    localparam int NSRC   = 2;
    localparam int DEPTH  = 3;
    localparam int DW     = 32;
    localparam int AW     = 5;
    localparam int TW     = 2;
    localparam int MD_LAT = 5;

    localparam logic [DW-1:0] RD0 = 32'hA0A0_0001;
    localparam logic [DW-1:0] RD1 = 32'hB1B1_0002;
    localparam logic [DW-1:0] W0  = 32'hE000_000E;
    localparam logic [DW-1:0] W1  = 32'h4D00_000D;
    localparam logic [DW-1:0] W2  = 32'h3300_0077;

    logic                clk = 1'b0;
    logic                reset;
    logic                d_valid;
    logic [NSRC*AW-1:0]  d_rs;
    logic [NSRC*TW-1:0]  d_tuse;
    logic [NSRC*DW-1:0]  d_rdata;
    logic                d_regwrite;
    logic [AW-1:0]       d_a3;
    logic [TW-1:0]       d_tnew;
    logic                d_md_start;
    logic                d_md_use;
    logic [DEPTH*DW-1:0] stage_wd;
    logic                stall;
    logic [NSRC*DW-1:0]  fwd_data;
    logic [NSRC-1:0]     fwd_pending;
    logic                md_busy;

    int errors = 0;
    int checks = 0;

    hazard_scoreboard #(
        .NSRC(NSRC), .DEPTH(DEPTH), .DW(DW), .AW(AW), .TW(TW), .MD_LAT(MD_LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .d_valid     (d_valid),
        .d_rs        (d_rs),
        .d_tuse      (d_tuse),
        .d_rdata     (d_rdata),
        .d_regwrite  (d_regwrite),
        .d_a3        (d_a3),
        .d_tnew      (d_tnew),
        .d_md_start  (d_md_start),
        .d_md_use    (d_md_use),
        .stage_wd    (stage_wd),
        .stall       (stall),
        .fwd_data    (fwd_data),
        .fwd_pending (fwd_pending),
        .md_busy     (md_busy)
    );

    always #5 clk = ~clk;

    // Reference model: each accepted writer is remembered with the cycle it entered E.
    // Its stage is (now - enter); its remaining Tnew is max(0, tnew - stage).
    typedef struct {
        int dst;
        int enter;
        int tn;
    } prod_t;

    prod_t prods[$];
    int    cyc = 0;
    int    md_start_cyc = -100000;

    function automatic void model(output logic st, output logic [NSRC*DW-1:0] fd,
                                  output logic [NSRC-1:0] pd, output logic mb);
        logic hz;
        mb = (cyc > md_start_cyc) && (cyc - md_start_cyc <= MD_LAT);
        hz = 1'b0;
        fd = d_rdata;
        pd = '0;
        for (int i = 0; i < NSRC; i++) begin
            int rs;
            int tu;
            int best;
            rs   = int'(d_rs[i*AW +: AW]);
            tu   = int'(d_tuse[i*TW +: TW]);
            best = -1;
            if (rs != 0) begin
                foreach (prods[j]) begin
                    int age;
                    age = cyc - prods[j].enter;
                    if (age >= 0 && age < DEPTH && prods[j].dst == rs &&
                        (best < 0 || prods[j].enter > prods[best].enter))
                        best = j;
                end
            end
            if (d_valid && best >= 0) begin
                int age;
                int rem;
                age = cyc - prods[best].enter;
                rem = prods[best].tn - age;
                if (rem < 0) rem = 0;
                if (rem == 0)      fd[i*DW +: DW] = stage_wd[age*DW +: DW];
                else if (rem <= tu) pd[i] = 1'b1;
                else               hz = 1'b1;
            end
        end
        st = d_valid && (hz || (d_md_use && mb));
    endfunction

    // Advance one clock; the model commits using its own stall prediction.
    task automatic tick();
        logic st;
        logic [NSRC*DW-1:0] fd;
        logic [NSRC-1:0] pd;
        logic mb;
        model(st, fd, pd, mb);
        @(posedge clk);
        if (reset) begin
            prods.delete();
            md_start_cyc = -100000;
        end else begin
            if (!st && d_valid && d_regwrite && d_a3 != '0)
                prods.push_back('{int'(d_a3), cyc + 1, int'(d_tnew)});
            if (d_valid && d_md_start && !st)
                md_start_cyc = cyc;
        end
        cyc++;
        while (prods.size() > 0 && cyc - prods[0].enter >= DEPTH)
            void'(prods.pop_front());
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input int rs0, input int tu0, input int rs1, input int tu1,
                         input logic rw, input int a3, input int tn, input logic mds, input logic mdu);
        d_valid    = v;
        d_rs       = {AW'(rs1), AW'(rs0)};
        d_tuse     = {TW'(tu1), TW'(tu0)};
        d_regwrite = rw;
        d_a3       = AW'(a3);
        d_tnew     = TW'(tn);
        d_md_start = mds;
        d_md_use   = mdu;
        d_rdata    = {RD1, RD0};
        stage_wd   = {W2, W1, W0};
        #1;
    endtask

    task automatic flush();
        drive(1'b0, 0, 0, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH + MD_LAT; i++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 0, 0, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        drive(1'b1, 8, 1, 9, 1, 1'b1, 10, 1, 1'b0, 1'b0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL reset_md_busy: got %b want 0", md_busy); end
        checks++; if (fwd_pending !== 2'b00) begin errors++; $display("FAIL reset_pending: got %b want 00", fwd_pending); end
        checks++; if (fwd_data !== {RD1, RD0}) begin errors++; $display("FAIL reset_fwd: got %h want %h", fwd_data, {RD1, RD0}); end
        tick();
        flush();
    endtask

    task automatic test_load_use();
        drive(1'b1, 0, 0, 0, 0, 1'b1, 8, 2, 1'b0, 1'b0);  // lw $8
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_lw_issue: stall=%b want 0", stall); end
        tick();
        drive(1'b1, 8, 1, 0, 0, 1'b1, 10, 1, 1'b0, 1'b0); // addu $10, $8
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall: stall=%b want 1", stall); end
        tick();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_release: stall=%b want 0", stall); end
        checks++; if (fwd_pending !== 2'b01) begin errors++; $display("FAIL lu_pending: got %b want 01", fwd_pending); end
        checks++; if (fwd_data[DW-1:0] !== RD0) begin errors++; $display("FAIL lu_fwd_grf: got %h want %h", fwd_data[DW-1:0], RD0); end
        tick();
        drive(1'b1, 8, 0, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0);  // lw now in W with tnew 0
        checks++; if (fwd_data[DW-1:0] !== W2) begin errors++; $display("FAIL lu_fwd_w: got %h want %h", fwd_data[DW-1:0], W2); end
        tick();
        flush();
    endtask

    task automatic test_youngest();
        drive(1'b1, 0, 0, 0, 0, 1'b1, 9, 1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 0, 0, 0, 0, 1'b1, 9, 1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 9, 0, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL young_stall: stall=%b want 1", stall); end
        tick();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL young_release: stall=%b want 0", stall); end
        checks++; if (fwd_data[DW-1:0] !== W1) begin errors++; $display("FAIL young_fwd_m: got %h want %h", fwd_data[DW-1:0], W1); end
        tick();
        flush();
    endtask

    task automatic test_md();
        drive(1'b1, 0, 0, 0, 0, 1'b0, 0, 0, 1'b1, 1'b1);  // mult
        checks++; if (stall !== 1'b0 || md_busy !== 1'b0) begin errors++; $display("FAIL md_issue: stall=%b busy=%b want 0 0", stall, md_busy); end
        tick();
        drive(1'b1, 0, 0, 0, 0, 1'b1, 11, 1, 1'b0, 1'b1); // mfhi $11
        for (int j = 0; j < MD_LAT; j++) begin
            checks++; if (stall !== 1'b1 || md_busy !== 1'b1) begin errors++; $display("FAIL md_wait%0d: stall=%b busy=%b want 1 1", j, stall, md_busy); end
            tick();
        end
        checks++; if (stall !== 1'b0 || md_busy !== 1'b0) begin errors++; $display("FAIL md_done: stall=%b busy=%b want 0 0", stall, md_busy); end
        tick();
        flush();
    endtask

    task automatic test_zero_reg();
        drive(1'b1, 0, 0, 0, 0, 1'b1, 0, 2, 1'b0, 1'b0);
        tick();
        drive(1'b1, 0, 0, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_stall: stall=%b want 0", stall); end
        checks++; if (fwd_pending !== 2'b00) begin errors++; $display("FAIL zero_pending: got %b want 00", fwd_pending); end
        checks++; if (fwd_data !== {RD1, RD0}) begin errors++; $display("FAIL zero_fwd: got %h want %h", fwd_data, {RD1, RD0}); end
        tick();
        flush();
    endtask

    task automatic test_invalid_d();
        drive(1'b1, 0, 0, 0, 0, 1'b1, 8, 2, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8, 0, 8, 2, 1'b0, 0, 0, 1'b0, 1'b0);
        checks++; if (stall !== 1'b0 || fwd_pending !== 2'b00) begin errors++; $display("FAIL novalid: stall=%b pend=%b want 0 00", stall, fwd_pending); end
        checks++; if (fwd_data !== {RD1, RD0}) begin errors++; $display("FAIL novalid_fwd: got %h want %h", fwd_data, {RD1, RD0}); end
        tick();
        flush();
    endtask

    task automatic test_reset_mid_stall();
        drive(1'b1, 0, 0, 0, 0, 1'b0, 0, 0, 1'b1, 1'b1);  // mult
        tick();
        drive(1'b1, 0, 0, 0, 0, 1'b1, 8, 2, 1'b0, 1'b0);  // lw $8
        tick();
        drive(1'b1, 8, 0, 0, 0, 1'b1, 12, 1, 1'b0, 1'b1);
        checks++; if (stall !== 1'b1 || md_busy !== 1'b1) begin errors++; $display("FAIL rst_pre: stall=%b busy=%b want 1 1", stall, md_busy); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++; if (stall !== 1'b0 || md_busy !== 1'b0) begin errors++; $display("FAIL rst_post: stall=%b busy=%b want 0 0", stall, md_busy); end
        checks++; if (fwd_pending !== 2'b00 || fwd_data !== {RD1, RD0}) begin errors++; $display("FAIL rst_post_fwd: pend=%b data=%h want 00 %h", fwd_pending, fwd_data, {RD1, RD0}); end
        tick();
        flush();
    endtask

    task automatic test_random();
        logic e_st;
        logic [NSRC*DW-1:0] e_fd;
        logic [NSRC-1:0] e_pd;
        logic e_mb;
        for (int n = 0; n < 2000; n++) begin
            reset      = ($urandom_range(0, 127) == 0);
            d_valid    = ($urandom_range(0, 9) != 0);
            d_rs       = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            d_tuse     = {TW'($urandom_range(0, 2)), TW'($urandom_range(0, 2))};
            d_rdata    = {DW'($urandom), DW'($urandom)};
            d_regwrite = ($urandom_range(0, 3) != 0);
            d_a3       = AW'($urandom_range(0, 7));
            d_tnew     = TW'($urandom_range(0, 2));
            d_md_start = ($urandom_range(0, 19) == 0);
            d_md_use   = d_md_start | ($urandom_range(0, 9) == 0);
            stage_wd   = {DW'($urandom), DW'($urandom), DW'($urandom)};
            #1;
            model(e_st, e_fd, e_pd, e_mb);
            checks++; if (stall !== e_st) begin errors++; $display("FAIL rnd_stall @%0d: got %b want %b", n, stall, e_st); end
            checks++; if (fwd_data !== e_fd) begin errors++; $display("FAIL rnd_fwd @%0d: got %h want %h", n, fwd_data, e_fd); end
            checks++; if (fwd_pending !== e_pd) begin errors++; $display("FAIL rnd_pending @%0d: got %b want %b", n, fwd_pending, e_pd); end
            checks++; if (md_busy !== e_mb) begin errors++; $display("FAIL rnd_md_busy @%0d: got %b want %b", n, md_busy, e_mb); end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 0, 0, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
        test_reset();
        test_load_use();
        test_youngest();
        test_md();
        test_zero_reg();
        test_invalid_d();
        test_reset_mid_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
